// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the key scan controller.
// Holds the FSM state encoding, default timings and the pin idle level.
package key_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HOLD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // 20 ms debounce and 1 s long press at 50 MHz
  localparam int DEF_DB_CNT   = 1_000_000;
  localparam int DEF_LONG_CNT = 50_000_000;

  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_sync.sv
// key_sync: W-bit two-flop synchronizer for raw key pins.
// Ports: sys_clk, sys_rst_n (async low), d (raw), q (synced, resets released).
module key_sync
  import key_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= {W{KEY_RELEASED}};
      q  <= {W{KEY_RELEASED}};
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: round-robin key debouncer with one shared counter.
// Ports: sys_clk, sys_rst_n, key_in (low = pressed), key_pulse,
// long_pulse (one-cycle, one-hot), key_code (serviced index), busy.
module key_scan_ctrl
  import key_pkg::*;
#(
  parameter int KEY_NUM  = 4,
  parameter int IDX_W    = 2,
  parameter int DB_CNT   = DEF_DB_CNT,
  parameter int LONG_CNT = DEF_LONG_CNT,
  parameter int CNT_W    = 26
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_pulse,
  output logic [KEY_NUM-1:0] long_pulse,
  output logic [IDX_W-1:0]   key_code,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(KEY_NUM - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  logic [KEY_NUM-1:0] ks;

  key_sync #(.W(KEY_NUM)) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d         (key_in),
    .q         (ks)
  );

  state_t             state, nxt_state;
  logic [IDX_W-1:0]   ptr, nxt_ptr;
  logic [IDX_W-1:0]   cur, nxt_cur;
  logic [IDX_W-1:0]   nxt_code;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic               long_done, nxt_long_done;
  logic [KEY_NUM-1:0] nxt_kp, nxt_lp;
  logic               cur_rel;

  function automatic logic [IDX_W-1:0] inc_idx(
    input logic [IDX_W-1:0] i
  );
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign cur_rel = (ks[cur] == KEY_RELEASED);
  assign busy    = (state != SCAN);

  always_comb begin
    nxt_state     = state;
    nxt_ptr       = ptr;
    nxt_cur       = cur;
    nxt_code      = key_code;
    nxt_cnt       = cnt;
    nxt_long_done = long_done;
    nxt_kp        = '0;
    nxt_lp        = '0;
    unique case (state)
      SCAN: begin
        nxt_ptr = inc_idx(ptr);
        if (ks[ptr] != KEY_RELEASED) begin
          nxt_cur   = ptr;
          nxt_code  = ptr;
          nxt_cnt   = '0;
          nxt_state = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (cur_rel) begin
          nxt_cnt   = '0;
          nxt_ptr   = inc_idx(cur);
          nxt_state = SCAN;
        end else if (cnt == DB_LAST) begin
          nxt_kp[cur]   = 1'b1;
          nxt_cnt       = '0;
          nxt_long_done = 1'b0;
          nxt_state     = HOLD;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cur_rel) begin
          nxt_cnt   = '0;
          nxt_state = REL_DB;
        end else if (cnt == LONG_LAST) begin
          // saturated; long_done keeps this to one pulse per press
          if (!long_done) begin
            nxt_lp[cur]   = 1'b1;
            nxt_long_done = 1'b1;
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      REL_DB: begin
        if (!cur_rel) begin
          nxt_cnt   = '0;
          nxt_state = HOLD;
        end else if (cnt == DB_LAST) begin
          nxt_cnt   = '0;
          nxt_ptr   = inc_idx(cur);
          nxt_state = SCAN;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: nxt_state = SCAN;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= SCAN;
      ptr        <= '0;
      cur        <= '0;
      key_code   <= '0;
      cnt        <= '0;
      long_done  <= 1'b0;
      key_pulse  <= '0;
      long_pulse <= '0;
    end else begin
      state      <= nxt_state;
      ptr        <= nxt_ptr;
      cur        <= nxt_cur;
      key_code   <= nxt_code;
      cnt        <= nxt_cnt;
      long_done  <= nxt_long_done;
      key_pulse  <= nxt_kp;
      long_pulse <= nxt_lp;
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed bench for key_scan_ctrl.
// KEY_NUM=4, DB_CNT=8, LONG_CNT=32; pulses logged on negedge.
module tb_key_scan_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] key_in;
  logic [3:0] key_pulse;
  logic [3:0] long_pulse;
  logic [1:0] key_code;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  key_scan_ctrl #(
    .KEY_NUM  (4),
    .IDX_W    (2),
    .DB_CNT   (8),
    .LONG_CNT (32),
    .CNT_W    (26)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_pulse  (key_pulse),
    .long_pulse (long_pulse),
    .key_code   (key_code),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int         cyc = 0;
  int         kp_cnt [4];
  int         lp_cnt [4];
  int         kp_time = 0;
  int         lp_time = 0;
  int         last_code = -1;
  int         prev_code = -1;
  logic [3:0] last_kp = '0;
  logic [3:0] last_lp = '0;
  int         viol = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      kp_cnt[i] = 0;
      lp_cnt[i] = 0;
    end
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if ($countones(key_pulse) > 1 || $countones(long_pulse) > 1 ||
        (|key_pulse && |long_pulse))
      viol++;
    if (|key_pulse) begin
      for (int i = 0; i < 4; i++)
        if (key_pulse[i]) kp_cnt[i]++;
      kp_time   = cyc;
      prev_code = last_code;
      last_code = int'(key_code);
      last_kp   = key_pulse;
    end
    if (|long_pulse) begin
      for (int i = 0; i < 4; i++)
        if (long_pulse[i]) lp_cnt[i]++;
      lp_time = cyc;
      last_lp = long_pulse;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_kp"}, 32'(key_pulse), 32'h0);
    chk({tag, "_lp"}, 32'(long_pulse), 32'h0);
    chk({tag, "_code"}, 32'(key_code), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  int c0;

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    step(2);
    chk_idle("reset");
    sys_rst_n = 1'b1;
    step(3);
    chk("idle_busy", 32'(busy), 32'h0);

    // clean press on key 2
    key_in = 4'b1011;
    step(20);
    key_in = 4'hF;
    step(14);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_code", 32'(key_code), 32'd2);
    chk("t1_kp2", 32'(kp_cnt[2]), 32'd1);
    chk("t1_kp0", 32'(kp_cnt[0]), 32'd0);
    chk("t1_vec", 32'(last_kp), 32'h4);
    chk("t1_lp", 32'(lp_cnt[2]), 32'd0);

    // bounces on key 1
    for (int r = 0; r < 3; r++) begin
      key_in = 4'b1101;
      step(5);
      key_in = 4'hF;
      step(10);
      chk("t2_busy", 32'(busy), 32'h0);
    end
    chk("t2_kp1", 32'(kp_cnt[1]), 32'd0);

    // long press on key 0 with a release glitch
    key_in = 4'b1110;
    step(50);
    chk("t3_kp0", 32'(kp_cnt[0]), 32'd1);
    chk("t3_lp0", 32'(lp_cnt[0]), 32'd1);
    chk("t3_lat", 32'(lp_time - kp_time), 32'd32);
    chk("t3_lvec", 32'(last_lp), 32'h1);
    key_in = 4'hF;
    step(3);
    key_in = 4'b1110;
    step(45);
    key_in = 4'hF;
    step(14);
    chk("t3_lp0_once", 32'(lp_cnt[0]), 32'd1);
    chk("t3_kp0_once", 32'(kp_cnt[0]), 32'd1);
    chk("t3_busy", 32'(busy), 32'h0);

    // simultaneous keys 1 and 2, pointer aligned by reset
    sys_rst_n = 1'b0;
    step(2);
    chk_idle("t4_rst");
    sys_rst_n = 1'b1;
    step(1);
    key_in = 4'b1001;
    step(30);
    key_in = 4'hF;
    step(14);
    chk("t4_kp1", 32'(kp_cnt[1]), 32'd1);
    chk("t4_kp2", 32'(kp_cnt[2]), 32'd1);
    chk("t4_code", 32'(last_code), 32'd1);
    chk("t4_vec", 32'(last_kp), 32'h2);
    chk("t4_busy", 32'(busy), 32'h0);

    // reset in the middle of key 3 debounce
    sys_rst_n = 1'b0;
    step(2);
    key_in    = 4'b0111;
    sys_rst_n = 1'b1;
    step(8);
    chk("t5_busy", 32'(busy), 32'h1);
    chk("t5_code", 32'(key_code), 32'd3);
    sys_rst_n = 1'b0;
    #1;
    chk_idle("t5_async");
    step(2);
    chk_idle("t5_rst");
    chk("t5_nopulse", 32'(kp_cnt[3]), 32'd0);
    sys_rst_n = 1'b1;
    c0 = cyc;
    step(20);
    chk("t5_kp3", 32'(kp_cnt[3]), 32'd1);
    chk("t5_lat", 32'(kp_time - c0), 32'd12);
    chk("t5_vec", 32'(last_kp), 32'h8);
    key_in = 4'hF;
    step(14);
    chk("t5_busy_end", 32'(busy), 32'h0);

    // key 3 then key 0: pointer wraps
    key_in = 4'b0111;
    step(20);
    key_in = 4'hF;
    step(14);
    key_in = 4'b1110;
    step(20);
    key_in = 4'hF;
    step(14);
    chk("t6_kp3", 32'(kp_cnt[3]), 32'd2);
    chk("t6_kp0", 32'(kp_cnt[0]), 32'd2);
    chk("t6_prev", 32'(prev_code), 32'd3);
    chk("t6_last", 32'(last_code), 32'd0);
    chk("t6_code", 32'(key_code), 32'd0);

    chk("onehot", 32'(viol), 32'd0);
    chk("lp_other", 32'(lp_cnt[1] + lp_cnt[2] + lp_cnt[3]), 32'd0);
    chk("lp_total0", 32'(lp_cnt[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
